spi_frame_slave: RTL and testbench

SPI_FRAME_SLAVE -- requirements
Module: spi_frame_slave

---
 rtl/spi_frame_slave.sv | 196 +++++++++++++++++++
 tb/tb_spi_frame_slave.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_slave.sv
// SPI frame slave: receives WIDTH-bit words on mosi, frames them by ss, and
// (with SPI_FRAME_SLAVE_TX_EN defined) returns buffered words on miso.
// sclk, ss and mosi are asynchronous and oversampled by clk (clk >= 8x sclk).
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   sclk, ss, mosi    SPI bus inputs (ss active-low)
//   miso              SPI serial data out (0 in IDLE / when TX disabled)
//   rx_data/rx_valid  last complete word and its one-cycle strobe
//   sot               with rx_valid, marks the first word of a frame
//   eot               one-cycle strobe at frame end
//   word_count        words received in the current/last frame
//   tx_data/tx_valid/tx_ready  single-word transmit buffer handshake
//   underrun          sticky: a tx word was needed while the buffer was empty
// Macro SPI_FRAME_SLAVE_TX_EN enables the transmit buffer and miso path.
module spi_frame_slave #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned CPHA        = 0,
  parameter int unsigned MSB_FIRST   = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             ss,
  input  logic             mosi,
  output logic             miso,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             sot,
  output logic             eot,
  output logic [CNT_W-1:0] word_count,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             underrun
);

  localparam int unsigned BC_W = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic sclk_q, ss_q;
  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, sample_edge;
  logic ss_fall, ss_rise;
  logic enter, leave;

  logic [WIDTH-1:0] rx_sr, rx_nx;
  logic [BC_W-1:0]  bit_cnt;
  logic             first_word;

  // Input synchronisers plus one delay flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      ss_q      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
      ss_q      <= ss_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign ss_s        = ss_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_q;
  assign sclk_fall   = ~sclk_s & sclk_q;
  assign sample_edge = (CPOL == CPHA) ? sclk_rise : sclk_fall;
  // Sync flops clear to 0, so a released ss after reset looks like a rise, never a fall
  assign ss_fall     = ~ss_s & ss_q;
  assign ss_rise     = ss_s & ~ss_q;

  // Frame state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Frame next-state logic
  always_comb begin
    state_nx = state;
    enter    = 1'b0;
    leave    = 1'b0;
    case (state)
      IDLE:    if (ss_fall) begin state_nx = ACTIVE; enter = 1'b1; end
      ACTIVE:  if (ss_rise) begin state_nx = IDLE;   leave = 1'b1; end
      default: state_nx = IDLE;
    endcase
  end

  assign rx_nx = (MSB_FIRST != 0) ? {rx_sr[WIDTH-2:0], mosi_s} : {mosi_s, rx_sr[WIDTH-1:1]};

  // Receive shifter, word strobe and frame counters
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sr      <= '0;
      bit_cnt    <= '0;
      first_word <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      sot        <= 1'b0;
      eot        <= 1'b0;
      word_count <= '0;
    end else begin
      rx_valid <= 1'b0;
      sot      <= 1'b0;
      eot      <= leave;
      if (enter) begin
        rx_sr      <= '0;
        bit_cnt    <= '0;
        first_word <= 1'b1;
        word_count <= '0;
      end else if (state == ACTIVE && !leave && sample_edge) begin
        rx_sr <= rx_nx;
        if (bit_cnt == BC_W'(WIDTH - 1)) begin
          bit_cnt    <= '0;
          rx_data    <= rx_nx;
          rx_valid   <= 1'b1;
          sot        <= first_word;
          first_word <= 1'b0;
          word_count <= word_count + CNT_W'(1);
        end else begin
          bit_cnt <= bit_cnt + BC_W'(1);
        end
      end
    end
  end

`ifdef SPI_FRAME_SLAVE_TX_EN
  logic             shift_edge, act_shift, need_word, take, empty_now;
  logic [WIDTH-1:0] tx_buf, tx_sr, tx_word, src, src_shift;
  logic [BC_W-1:0]  tx_cnt;
  logic             src_bit;

  assign shift_edge = (CPOL == CPHA) ? sclk_fall : sclk_rise;
  assign act_shift  = (state == ACTIVE) && !leave && shift_edge;
  // tx_cnt counts bits of the current word already on miso; WIDTH means reload
  assign need_word  = enter || (act_shift && tx_cnt == BC_W'(WIDTH));
  assign take       = tx_valid & tx_ready;
  // A word offered in the reload cycle bypasses the buffer
  assign tx_word    = !tx_ready ? tx_buf : (take ? tx_data : '0);
  assign empty_now  = tx_ready & ~take;
  assign src        = need_word ? tx_word : tx_sr;
  assign src_bit    = (MSB_FIRST != 0) ? src[WIDTH-1] : src[0];
  assign src_shift  = (MSB_FIRST != 0) ? (src << 1) : (src >> 1);

  // Transmit buffer, shift register and miso
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_buf   <= '0;
      tx_ready <= 1'b1;
      tx_sr    <= '0;
      tx_cnt   <= '0;
      miso     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (need_word)  tx_ready <= 1'b1;
      else if (take) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end
      if (need_word) underrun <= (enter ? 1'b0 : underrun) | empty_now;
      if (enter && CPHA != 0) begin
        // CPHA=1: first bit appears on the first shift edge
        tx_sr  <= tx_word;
        miso   <= 1'b0;
        tx_cnt <= '0;
      end else if (enter || act_shift) begin
        tx_sr  <= src_shift;
        miso   <= src_bit;
        tx_cnt <= need_word ? BC_W'(1) : tx_cnt + BC_W'(1);
      end else if (leave || state == IDLE) begin
        miso <= 1'b0;
      end
    end
  end
`else
  logic unused_tx;
  assign unused_tx = ^{tx_data, tx_valid};
  assign miso      = 1'b0;
  assign tx_ready  = 1'b0;
  assign underrun  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_slave.sv
module tb_spi_frame_slave;

`ifdef SPI_FRAME_SLAVE_TX_EN
  localparam bit TX_ON = 1'b1;
`else
  localparam bit TX_ON = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       sot;
  } exp_t;

  typedef struct {
    int         tgt;
    int         n;
    logic [7:0] rx0, rx1, tx0, tx1;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   tgt;
  logic sclk_m, ss_m, mosi_m, txv_m;
  logic [7:0] txd_m;

  logic sclk0, ss0, miso0, rxv0, sot0, eot0, txv0, txr0, und0;
  logic sclk3, ss3, miso3, rxv3, sot3, eot3, txv3, txr3, und3;
  logic [7:0]  rxd0, rxd3;
  logic [15:0] wc0, wc3;

  int total = 0;
  int bad   = 0;
  int eot_cnt = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  assign sclk0 = (tgt == 0) ? sclk_m : 1'b0;
  assign ss0   = (tgt == 0) ? ss_m   : 1'b1;
  assign txv0  = (tgt == 0) ? txv_m  : 1'b0;
  assign sclk3 = (tgt == 3) ? sclk_m : 1'b1;
  assign ss3   = (tgt == 3) ? ss_m   : 1'b1;
  assign txv3  = (tgt == 3) ? txv_m  : 1'b0;

  spi_frame_slave u0 (
    .clk(clk), .rst(rst), .sclk(sclk0), .ss(ss0), .mosi(mosi_m), .miso(miso0),
    .rx_data(rxd0), .rx_valid(rxv0), .sot(sot0), .eot(eot0), .word_count(wc0),
    .tx_data(txd_m), .tx_valid(txv0), .tx_ready(txr0), .underrun(und0)
  );

  spi_frame_slave #(.CPOL(1), .CPHA(1), .MSB_FIRST(0)) u3 (
    .clk(clk), .rst(rst), .sclk(sclk3), .ss(ss3), .mosi(mosi_m), .miso(miso3),
    .rx_data(rxd3), .rx_valid(rxv3), .sot(sot3), .eot(eot3), .word_count(wc3),
    .tx_data(txd_m), .tx_valid(txv3), .tx_ready(txr3), .underrun(und3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon(input string who, input logic [7:0] d, input logic s);
    exp_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL rx_unexpected(%s): got %0h expected no word", who, d);
    end else begin
      e = q.pop_front();
      chk("rx_data", 32'(d), 32'(e.data));
      chk("rx_sot", 32'(s), 32'(e.sot));
    end
  endtask

  // Scoreboard pop on each rx strobe; eot pulses counted per high cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (rxv0) mon("u0", rxd0, sot0);
      if (rxv3) mon("u3", rxd3, sot3);
      if (sot0 && !rxv0) chk("sot_alone_u0", 32'(sot0), 32'd0);
      if (sot3 && !rxv3) chk("sot_alone_u3", 32'(sot3), 32'd0);
      if (eot0) eot_cnt++;
      if (eot3) eot_cnt++;
    end
  end

  function automatic logic [31:0] wc_t();
    return (tgt == 3) ? 32'(wc3) : 32'(wc0);
  endfunction

  function automatic logic miso_t();
    return (tgt == 3) ? miso3 : miso0;
  endfunction

  function automatic logic und_t();
    return (tgt == 3) ? und3 : und0;
  endfunction

  function automatic logic txr_t();
    return (tgt == 3) ? txr3 : txr0;
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic select(input int t);
    tgt    = t;
    sclk_m = (t == 3);
    ss_m   = 1'b1;
    clks(8);
  endtask

  task automatic ss_assert();
    ss_m = 1'b0;
    clks(16);
  endtask

  task automatic ss_release();
    clks(8);
    ss_m = 1'b1;
    clks(16);
  endtask

  task automatic push_tx(input logic [7:0] w);
    int k;
    k = 0;
    while (!txr_t() && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!txr_t()) begin
      total++;
      bad++;
      $display("FAIL tx_ready_timeout: got 0 expected 1");
    end
    txd_m = w;
    txv_m = 1'b1;
    @(negedge clk);
    txv_m = 1'b0;
  endtask

  // Master side: drives n bits of w in the target's bit order, samples miso
  task automatic send_bits(input logic [7:0] w, input int n, output logic [7:0] rcv);
    logic cp, msb;
    int   idx;
    cp  = (tgt == 3);
    msb = (tgt == 0);
    rcv = '0;
    for (int i = 0; i < n; i++) begin
      idx = msb ? 7 - i : i;
      if (!cp) begin
        mosi_m = w[idx];
        clks(8);
        sclk_m = 1'b1;
        rcv[idx] = miso_t();
        clks(8);
        sclk_m = 1'b0;
      end else begin
        sclk_m = 1'b0;
        mosi_m = w[idx];
        clks(8);
        sclk_m = 1'b1;
        rcv[idx] = miso_t();
        clks(8);
      end
    end
  endtask

  vec_t vecs[5];

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    int e0;
    vecs[0] = '{tgt: 0, n: 2, rx0: 8'hA5, rx1: 8'h3C, tx0: 8'h12, tx1: 8'h34};
    vecs[1] = '{tgt: 3, n: 2, rx0: 8'h01, rx1: 8'h80, tx0: 8'h5A, tx1: 8'hC3};
    vecs[2] = '{tgt: 0, n: 1, rx0: 8'h00, rx1: 8'h00, tx0: 8'hFF, tx1: 8'h00};
    vecs[3] = '{tgt: 3, n: 2, rx0: 8'hFF, rx1: 8'h6E, tx0: 8'h81, tx1: 8'h7E};
    vecs[4] = '{tgt: 0, n: 2, rx0: 8'h96, rx1: 8'h0F, tx0: 8'h01, tx1: 8'h80};

    rst = 1'b1; tgt = 0; sclk_m = 1'b0; ss_m = 1'b1; mosi_m = 1'b0;
    txv_m = 1'b0; txd_m = '0;
    clks(4);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rx_data0", 32'(rxd0), 32'd0);
    chk("rst_rx_valid0", 32'(rxv0), 32'd0);
    chk("rst_eot0", 32'(eot0), 32'd0);
    chk("rst_wc0", 32'(wc0), 32'd0);
    chk("rst_miso0", 32'(miso0), 32'd0);
    chk("rst_underrun0", 32'(und0), 32'd0);
    chk("rst_tx_ready0", 32'(txr0), 32'(TX_ON));
    chk("rst_tx_ready3", 32'(txr3), 32'(TX_ON));
    chk("rst_miso3", 32'(miso3), 32'd0);

    for (int i = 0; i < 5; i++) begin
      select(vecs[i].tgt);
      if (TX_ON) push_tx(vecs[i].tx0);
      e0 = eot_cnt;
      ss_assert();
      if (TX_ON && vecs[i].n > 1) push_tx(vecs[i].tx1);
      q.push_back('{data: vecs[i].rx0, sot: 1'b1});
      send_bits(vecs[i].rx0, 8, r);
      chk("miso_w0", 32'(r), TX_ON ? 32'(vecs[i].tx0) : 32'd0);
      if (vecs[i].n > 1) begin
        q.push_back('{data: vecs[i].rx1, sot: 1'b0});
        send_bits(vecs[i].rx1, 8, r);
        chk("miso_w1", 32'(r), TX_ON ? 32'(vecs[i].tx1) : 32'd0);
      end
      ss_release();
      chk("eot_count", 32'(eot_cnt - e0), 32'd1);
      chk("word_count", wc_t(), 32'(vecs[i].n));
      chk("queue_empty", 32'(q.size()), 32'd0);
      chk("miso_idle", 32'(miso_t()), 32'd0);
      if (vecs[i].tgt == 3) chk("no_underrun", 32'(und_t()), 32'd0);
    end

    // Frame ends 5 bits into the second word
    select(0);
    e0 = eot_cnt;
    ss_assert();
    q.push_back('{data: 8'hA5, sot: 1'b1});
    send_bits(8'hA5, 8, r);
    send_bits(8'h3C, 5, r);
    ss_release();
    chk("partial_eot", 32'(eot_cnt - e0), 32'd1);
    chk("partial_wc", wc_t(), 32'd1);
    chk("partial_queue", 32'(q.size()), 32'd0);
    ss_assert();
    q.push_back('{data: 8'h42, sot: 1'b1});
    send_bits(8'h42, 8, r);
    ss_release();
    chk("after_partial_wc", wc_t(), 32'd1);
    chk("after_partial_queue", 32'(q.size()), 32'd0);

    // Buffer left empty for the second word
    select(3);
    if (TX_ON) push_tx(8'h77);
    ss_assert();
    chk("und_start", 32'(und_t()), 32'd0);
    q.push_back('{data: 8'h11, sot: 1'b1});
    send_bits(8'h11, 8, r);
    chk("und_miso_w0", 32'(r), TX_ON ? 32'h77 : 32'd0);
    q.push_back('{data: 8'h22, sot: 1'b0});
    send_bits(8'h22, 8, r);
    chk("und_miso_w1", 32'(r), 32'd0);
    chk("und_set", 32'(und_t()), 32'(TX_ON));
    ss_release();
    chk("und_sticky", 32'(und_t()), 32'(TX_ON));
    if (TX_ON) push_tx(8'h33);
    ss_assert();
    chk("und_cleared", 32'(und_t()), 32'd0);
    q.push_back('{data: 8'h44, sot: 1'b1});
    send_bits(8'h44, 8, r);
    chk("und_miso_next", 32'(r), TX_ON ? 32'h33 : 32'd0);
    ss_release();

    // Reset mid-word: abort without eot, then a fresh frame
    select(0);
    e0 = eot_cnt;
    ss_assert();
    send_bits(8'hA5, 3, r);
    @(negedge clk);
    rst = 1'b1;
    clks(2);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_rx_data", 32'(rxd0), 32'd0);
    chk("mrst_rx_valid", 32'(rxv0), 32'd0);
    chk("mrst_wc", 32'(wc0), 32'd0);
    chk("mrst_miso", 32'(miso0), 32'd0);
    chk("mrst_underrun", 32'(und0), 32'd0);
    chk("mrst_tx_ready", 32'(txr0), 32'(TX_ON));
    ss_m = 1'b1;
    clks(16);
    chk("mrst_no_eot", 32'(eot_cnt - e0), 32'd0);
    ss_assert();
    q.push_back('{data: 8'hFF, sot: 1'b1});
    send_bits(8'hFF, 8, r);
    ss_release();
    chk("mrst_next_eot", 32'(eot_cnt - e0), 32'd1);
    chk("mrst_next_wc", wc_t(), 32'd1);
    chk("final_queue", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
